// File: rtl/int_sequencer.sv
// Interrupt entry/return sequencer for the 5-stage pipeline: edge-latched requests,
// fixed-priority nesting, flush + PC redirect on entry and ERET, per-level EPC stack.
module int_sequencer #(
    parameter int N_SRC = 3,
    parameter int PC_W  = 32
) (
    input  logic             in_CLK,
    input  logic             in_RST,
    input  logic             in_EN,
    input  logic [N_SRC-1:0] in_IRQ,
    input  logic             in_STALL,
    input  logic             in_ERET,
    input  logic [PC_W-1:0]  in_PC,
    output logic [N_SRC-1:0] out_PEND,
    output logic [N_SRC-1:0] out_ACT,
    output logic             out_FLUSH,
    output logic [1:0]       out_PCSEL,
    output logic [1:0]       out_VEC,
    output logic [PC_W-1:0]  out_EPC
);
    localparam int SP_W = $clog2(N_SRC + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ENTER, RET} state_t;

    state_t                  state;
    logic [N_SRC-1:0]        irq_prev;
    logic                    armed;
    logic [N_SRC-1:0]        pend;
    logic [N_SRC-1:0]        act;
    logic [PC_W-1:0]         stack [N_SRC];
    logic [SP_W-1:0]         sp;
    logic [PC_W-1:0]         ret_epc;

    logic [N_SRC-1:0]        edges;
    logic [N_SRC-1:0]        elig;
    logic                    cand_vld;
    logic [1:0]              cand;
    logic [SP_W-1:0]         sp_m1;
    logic [PC_W-1:0]         top;
    logic                    enter_go;
    logic                    ret_go;

    // Sources strictly above the highest in-service level; all sources when none active.
    function automatic logic [N_SRC-1:0] above_mask(input logic [N_SRC-1:0] a);
        above_mask = '1;
        for (int i = 0; i < N_SRC; i++)
            if (a[i]) above_mask = {N_SRC{1'b1}} << (i + 1);
    endfunction

    function automatic logic [1:0] hi_idx(input logic [N_SRC-1:0] a);
        hi_idx = '0;
        for (int i = 0; i < N_SRC; i++)
            if (a[i]) hi_idx = i[1:0];
    endfunction

    // The first cycle after reset only primes irq_prev, so a level already high is not an edge.
    always_comb begin
        edges    = armed ? (in_IRQ & ~irq_prev) : '0;
        elig     = pend & above_mask(act);
        cand_vld = |elig;
        cand     = hi_idx(elig);
        sp_m1    = sp - 1'b1;
        top      = (sp == '0) ? '0 : stack[sp_m1];
        enter_go = (state == WAIT) && cand_vld && !in_STALL && in_EN;
        ret_go   = ((state == IDLE) && in_ERET && in_EN && (act != '0) && !in_STALL) ||
                   ((state == RET) && !out_FLUSH && in_EN && !in_STALL);
    end

    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            state     <= IDLE;
            irq_prev  <= '0;
            armed     <= 1'b0;
            pend      <= '0;
            act       <= '0;
            sp        <= '0;
            ret_epc   <= '0;
            out_FLUSH <= 1'b0;
            out_PCSEL <= 2'b00;
            out_VEC   <= 2'b00;
            for (int i = 0; i < N_SRC; i++) stack[i] <= '0;
        end else begin
            irq_prev  <= in_IRQ;
            armed     <= 1'b1;
            pend      <= pend | edges;
            out_FLUSH <= 1'b0;
            out_PCSEL <= 2'b00;
            out_VEC   <= 2'b00;

            case (state)
                IDLE: begin
                    if (in_ERET && in_EN && (act != '0)) state <= RET;
                    else if (cand_vld && in_EN)          state <= WAIT;
                end
                WAIT: begin
                    if (!cand_vld)    state <= IDLE;
                    else if (enter_go) state <= ENTER;
                end
                ENTER: state <= IDLE;
                RET: begin
                    // RET lingers while a stalled return waits; it leaves after the flush cycle.
                    if (out_FLUSH) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (enter_go) begin
                out_FLUSH  <= 1'b1;
                out_PCSEL  <= 2'b01;
                out_VEC    <= cand;
                stack[sp]  <= in_PC;
                sp         <= sp + 1'b1;
                act[cand]  <= 1'b1;
                pend       <= (pend & ~({{(N_SRC-1){1'b0}}, 1'b1} << cand)) | edges;
            end

            if (ret_go) begin
                out_FLUSH         <= 1'b1;
                out_PCSEL         <= 2'b10;
                ret_epc           <= top;
                stack[sp_m1]      <= '0;
                sp                <= sp_m1;
                act[hi_idx(act)]  <= 1'b0;
            end
        end
    end

    assign out_PEND = pend;
    assign out_ACT  = act;
    // During the return cycle the popped address is what the PC mux needs to see.
    assign out_EPC  = (out_PCSEL == 2'b10) ? ret_epc : top;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: entry/return timing, nesting, stalls, enable and reset.
module tb_int_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  irq;
    logic        stall;
    logic        eret;
    logic [31:0] pc;
    logic [2:0]  pend;
    logic [2:0]  act;
    logic        flush;
    logic [1:0]  pcsel;
    logic [1:0]  vec;
    logic [31:0] epc;

    int n_chk  = 0;
    int n_pass = 0;

    int_sequencer #(.N_SRC(3), .PC_W(32)) dut (
        .in_CLK(clk), .in_RST(rst), .in_EN(en), .in_IRQ(irq), .in_STALL(stall),
        .in_ERET(eret), .in_PC(pc), .out_PEND(pend), .out_ACT(act), .out_FLUSH(flush),
        .out_PCSEL(pcsel), .out_VEC(vec), .out_EPC(epc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic eret_pulse();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic chk_enter(input string tag, input logic [1:0] v, input logic [31:0] e,
                             input logic [2:0] a, input logic [2:0] p);
        chk({tag, ".flush"}, flush, 1'b1);
        chk({tag, ".pcsel"}, pcsel, 2'b01);
        chk({tag, ".vec"},   vec, v);
        chk({tag, ".epc"},   epc, e);
        chk({tag, ".act"},   act, a);
        chk({tag, ".pend"},  pend, p);
    endtask

    task automatic chk_ret(input string tag, input logic [31:0] e, input logic [2:0] a);
        chk({tag, ".flush"}, flush, 1'b1);
        chk({tag, ".pcsel"}, pcsel, 2'b10);
        chk({tag, ".epc"},   epc, e);
        chk({tag, ".act"},   act, a);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; irq = '0; stall = 1'b0; eret = 1'b0; pc = '0;
        #1;
        chk("rst.pend", pend, 3'b000);
        chk("rst.flush", flush, 1'b0);
        tick(2);
        chk("rst.act", act, 3'b000);
        chk("rst.pcsel", pcsel, 2'b00);
        chk("rst.epc", epc, 32'h0);
        rst = 1'b0;
        tick();

        // ERET with nothing active is ignored
        eret_pulse();
        chk("eret_idle.flush", flush, 1'b0);
        tick();

        // single entry/return on source 0
        irq = 3'b001; pc = 32'h40;
        tick();
        chk("s1.pend", pend, 3'b001);
        tick();
        chk("s1.noflush", flush, 1'b0);
        tick();
        chk_enter("s1.enter", 2'd0, 32'h40, 3'b001, 3'b000);
        tick();
        chk("s1.flush_off", flush, 1'b0);
        eret_pulse();
        chk_ret("s1.ret", 32'h40, 3'b000);
        tick();
        chk("s1.epc_empty", epc, 32'h0);

        // nesting: source 1 then source 2
        irq = 3'b010; pc = 32'h60;
        tick(3);
        chk_enter("s2.enter1", 2'd1, 32'h60, 3'b010, 3'b000);
        tick();
        irq = 3'b110; pc = 32'h80;
        tick(3);
        chk_enter("s2.enter2", 2'd2, 32'h80, 3'b110, 3'b000);
        tick();
        eret_pulse();
        chk_ret("s2.ret1", 32'h80, 3'b010);
        tick();
        chk("s2.top", epc, 32'h60);
        eret_pulse();
        chk_ret("s2.ret2", 32'h60, 3'b000);
        tick();

        // lower priority held while source 2 active
        irq = 3'b000; tick();
        irq = 3'b100; pc = 32'h100;
        tick(3);
        chk_enter("s3.enter2", 2'd2, 32'h100, 3'b100, 3'b000);
        tick();
        irq = 3'b101;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s3.held_flush", flush, 1'b0);
            chk("s3.held_pend", pend, 3'b001);
        end
        pc = 32'h200;
        eret_pulse();
        chk_ret("s3.ret", 32'h100, 3'b000);
        tick(2);
        chk("s3.wait_flush", flush, 1'b0);
        tick();
        chk_enter("s3.enter0", 2'd0, 32'h200, 3'b001, 3'b000);
        tick();
        eret_pulse();
        chk_ret("s3.ret0", 32'h200, 3'b000);
        tick();

        // stall while waiting, then stalled ERET
        irq = 3'b000; tick();
        irq = 3'b001; pc = 32'h300;
        tick(2);
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s4.stall_flush", flush, 1'b0);
        end
        stall = 1'b0;
        tick();
        chk_enter("s4.enter", 2'd0, 32'h300, 3'b001, 3'b000);
        tick();
        stall = 1'b1;
        eret_pulse();
        chk("s4.ret_held", flush, 1'b0);
        tick();
        chk("s4.ret_held2", flush, 1'b0);
        chk("s4.ret_held_act", act, 3'b001);
        stall = 1'b0;
        tick();
        chk_ret("s4.ret", 32'h300, 3'b000);
        tick();

        // simultaneous edges on 0 and 2
        irq = 3'b000; tick();
        irq = 3'b101; pc = 32'h400;
        tick();
        chk("s5.pend", pend, 3'b101);
        tick(2);
        chk_enter("s5.enter2", 2'd2, 32'h400, 3'b100, 3'b001);
        tick(2);
        chk("s5.no_enter0", flush, 1'b0);
        pc = 32'h500;
        eret_pulse();
        chk_ret("s5.ret2", 32'h400, 3'b000);
        tick(3);
        chk_enter("s5.enter0", 2'd0, 32'h500, 3'b001, 3'b000);
        tick();
        eret_pulse();
        tick();

        // reset while waiting with source 2 pending
        irq = 3'b000; tick();
        irq = 3'b100; tick();
        chk("s6.pend_pre", pend, 3'b100);
        tick();
        rst = 1'b1;
        #1;
        chk("s6.rst_pend", pend, 3'b000);
        chk("s6.rst_flush", flush, 1'b0);
        chk("s6.rst_pcsel", pcsel, 2'b00);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s6.level_pend", pend, 3'b000);
            chk("s6.level_flush", flush, 1'b0);
        end
        irq = 3'b000; tick();
        irq = 3'b100; pc = 32'h600;
        tick();
        chk("s6.new_pend", pend, 3'b100);
        tick(2);
        chk_enter("s6.enter", 2'd2, 32'h600, 3'b100, 3'b000);
        tick();
        eret_pulse();
        tick();

        // enable low freezes dispatch but still latches
        en = 1'b0;
        irq = 3'b000; tick();
        irq = 3'b010; pc = 32'h700;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s7.frozen_flush", flush, 1'b0);
        end
        chk("s7.frozen_pend", pend, 3'b010);
        en = 1'b1;
        tick(2);
        chk_enter("s7.enter", 2'd1, 32'h700, 3'b010, 3'b000);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
